taus_urng_mc: RTL and testbench
===============================

# taus_urng_mc

Multi-channel, parametrised Tausworthe (taus88-style, three 32-bit components) uniform random number generator. It is the next generation of the single-channel 64-bit Tausworthe URNG and the uniform source for the ICDF Gaussian path. It adds per-channel seeding, a warm-up phase, pause/resume without losing state, and a valid/ready output handshake. Each cycle in which a word is accepted, all NCH channels advance one step in lockstep.

## Interface

**Parameters**
- NCH, 4: number of independent generator channels (≥1).
- SEED1, 32'h1234_5678: reset value of component s1, channel 0.
- SEED2, 32'h9ABC_DEF0: reset value of component s2, channel 0.
- SEED3, 32'h0FED_CBA9: reset value of component s3, channel 0.
- SEED_STRIDE, 32'h9E37_79B9: channel c resets each sk to SEEDk + c·SEED_STRIDE (mod 2^32).
- WARMUP, 16: steps discarded after reset or seed load (0 = no warm-up).

**Ports**
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- en  in  1  run enable; 0 = pause.
- seed_we  in  1  seed write strobe (honoured only in IDLE).
- seed_ch  in  CW  target channel, CW = max(1, clog2(NCH)); values ≥NCH are ignored.
- seed_sel  in  2  0→s1, 1→s2, 2→s3, 3 ignored.
- seed_data  in  32  seed value.
- busy  out  1  high while in WARM.
- out_valid  out  1  out_data holds an unconsumed word.
- out_ready  in  1  consumer accepts when out_valid&&out_ready.
- out_data  out  32·NCH  channel c at bits [32c+31:32c].

## Operation

- Step per channel, all widths 32-bit, bits shifted out are discarded:
  - s1' = ((s1 & FFFFFFFE)<<12) ^ (((s1<<13)^s1)>>19)
  - s2' = ((s2 & FFFFFFF8)<<4) ^ (((s2<<2)^s2)>>25)
  - s3' = ((s3 & FFFFFFF0)<<17) ^ (((s3<<3)^s3)>>11)
  - word = s1'^s2'^s3', computed combinationally from the new state in the same cycle. No intermediate pipeline registers.
- need_warm flag: set by reset and by any honoured seed write. Cleared when WARM completes.
- FSM states are IDLE, WARM and RUN.
  - IDLE, en=1: go to WARM if need_warm && WARMUP>0, otherwise go to RUN. If need_warm is set with WARMUP=0, clear it.
  - WARM: all channels step every cycle; the counter runs 0..WARMUP-1. On the cycle the counter reaches WARMUP-1, go to RUN.
  - RUN: if !out_valid || out_ready, step all channels, load out_data with the words, and set out_valid=1. Otherwise hold the state and out_data.
  - Any state, en=0: go to IDLE next cycle. Generator state is retained. No step occurs in the cycle en is sampled low.
- In IDLE, out_valid/out_data remain until handshaked.
- An honoured seed write clears out_valid (stale flush) and resets the WARM counter.
- Re-entering RUN from IDLE with need_warm=0 continues the sequence with no warm-up.

## Timing

- Reset (asynchronous, immediate): state IDLE, out_valid=0, out_data=0, busy=0, need_warm=1, seeds as set by the parameters.
- en rising in IDLE at edge E: state is WARM after E.
  - busy is high for exactly WARMUP cycles.
  - The first out_valid rises one edge after entering RUN, i.e. at edge E+WARMUP+1.
- Sustained throughput is one word per cycle while out_ready=1.
- Backpressure:
  - out_data is stable while out_valid && !out_ready.
  - No step is lost or skipped. Consecutive accepted words are consecutive steps.
- seed_we in WARM or RUN is ignored.
- seed_we and en=1 in the same IDLE cycle: the write is honoured and the transition is taken with need_warm=1.
- rst asserted mid-RUN or mid-WARM: all outputs take their reset values without waiting for a clock edge.

## Configuration

- TAUS_SEED_FIX_EN defined: honoured seed writes are sanitised before storage.
  - s1 <2 → s1|2.
  - s2 <8 → s2|8.
  - s3 <16 → s3|16.
  - This guarantees non-degenerate components.
- TAUS_SEED_FIX_EN undefined: seeds are stored raw. A degenerate seed (e.g. all zero) gives a stuck component; an all-zero channel outputs constant 0.
- Parameter seeds are not sanitised in either build.

## Test plan

- Reset, en=1, WARMUP=16, out_ready=1 → busy high 16 cycles; first out_valid at edge 17 after en; each channel equals a golden model stepped 17 times; then one word per cycle for 1000 cycles.
- In RUN, out_ready=0 for 10 cycles then 1 → out_data constant during the stall; the next accepted word is exactly the following golden step.
- IDLE, write ch2 s1/s2/s3 = 1/2/3, en=1 → with macro, ch2 matches golden from seeds 3/10/19 after 16 warm-up steps; without macro, it matches golden from seeds 1/2/3. Other channels are unaffected.
- No macro, write ch0 seeds 0/0/0 → ch0 out_data bits [31:0] = 0 for every word. With macro, ch0 is nonzero and matches golden from 2/8/16.
- en dropped for 5 cycles mid-RUN, then raised → busy stays 0; the accepted-word sequence continues with no gap or repeat.
- rst pulsed between clock edges mid-RUN → out_valid, out_data and busy go to 0 immediately; after release with en=1, the sequence restarts identical to the first scenario.

Source files
------------

// File: rtl/taus_urng_mc.sv
// rtl/taus_urng_mc.sv - multi-channel taus88 uniform RNG with warm-up, pause and valid/ready output
// Optional TAUS_SEED_FIX_EN: sanitise written seeds so no component is degenerate.
module taus_urng_mc #(
  parameter int unsigned NCH         = 4,
  parameter logic [31:0] SEED1       = 32'h1234_5678,
  parameter logic [31:0] SEED2       = 32'h9ABC_DEF0,
  parameter logic [31:0] SEED3       = 32'h0FED_CBA9,
  parameter logic [31:0] SEED_STRIDE = 32'h9E37_79B9,
  parameter int unsigned WARMUP      = 16,
  localparam int unsigned CW         = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              seed_we,
  input  logic [CW-1:0]     seed_ch,
  input  logic [1:0]        seed_sel,
  input  logic [31:0]       seed_data,
  output logic              busy,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [32*NCH-1:0] out_data
);

  typedef enum logic [1:0] {IDLE, WARM, RUN} state_t;

  state_t                  state_q;
  logic [NCH-1:0][31:0]    s1_q, s2_q, s3_q;
  logic [NCH-1:0][31:0]    n1_d, n2_d, n3_d;
  logic [32*NCH-1:0]       word_d;
  logic [32*NCH-1:0]       out_data_q;
  logic                    out_valid_q;
  logic                    need_warm_q;
  logic [31:0]             cnt_q;
  logic [31:0]             seed_val;
  logic                    seed_hon;
  logic                    step_en;

  function automatic logic [31:0] step1(input logic [31:0] s);
    return ((s & 32'hFFFF_FFFE) << 12) ^ (((s << 13) ^ s) >> 19);
  endfunction

  function automatic logic [31:0] step2(input logic [31:0] s);
    return ((s & 32'hFFFF_FFF8) << 4) ^ (((s << 2) ^ s) >> 25);
  endfunction

  function automatic logic [31:0] step3(input logic [31:0] s);
    return ((s & 32'hFFFF_FFF0) << 17) ^ (((s << 3) ^ s) >> 11);
  endfunction

  always_comb begin
    n1_d   = s1_q;
    n2_d   = s2_q;
    n3_d   = s3_q;
    word_d = '0;
    for (int c = 0; c < int'(NCH); c++) begin
      n1_d[c] = step1(s1_q[c]);
      n2_d[c] = step2(s2_q[c]);
      n3_d[c] = step3(s3_q[c]);
      word_d[32*c +: 32] = n1_d[c] ^ n2_d[c] ^ n3_d[c];
    end
  end

  always_comb begin
    seed_val = seed_data;
`ifdef TAUS_SEED_FIX_EN
    case (seed_sel)
      2'd0:    if (seed_data < 32'd2)  seed_val = seed_data | 32'd2;
      2'd1:    if (seed_data < 32'd8)  seed_val = seed_data | 32'd8;
      2'd2:    if (seed_data < 32'd16) seed_val = seed_data | 32'd16;
      default: seed_val = seed_data;
    endcase
`endif
  end

  assign seed_hon = seed_we && (state_q == IDLE) && (seed_sel != 2'd3) && (32'(seed_ch) < NCH);
  assign step_en  = en && ((state_q == WARM) || ((state_q == RUN) && (!out_valid_q || out_ready)));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      need_warm_q <= 1'b1;
      cnt_q       <= '0;
      for (int c = 0; c < int'(NCH); c++) begin
        s1_q[c] <= SEED1 + 32'(c) * SEED_STRIDE;
        s2_q[c] <= SEED2 + 32'(c) * SEED_STRIDE;
        s3_q[c] <= SEED3 + 32'(c) * SEED_STRIDE;
      end
    end else begin
      if (out_valid_q && out_ready) out_valid_q <= 1'b0;

      // Seed writes land before the FSM so a same-cycle IDLE exit sees need_warm set.
      if (seed_hon) begin
        case (seed_sel)
          2'd0:    s1_q[seed_ch] <= seed_val;
          2'd1:    s2_q[seed_ch] <= seed_val;
          2'd2:    s3_q[seed_ch] <= seed_val;
          default: ;
        endcase
        need_warm_q <= 1'b1;
        out_valid_q <= 1'b0;
        cnt_q       <= '0;
      end

      if (step_en) begin
        s1_q <= n1_d;
        s2_q <= n2_d;
        s3_q <= n3_d;
      end

      if (!en) begin
        state_q <= IDLE;
      end else begin
        case (state_q)
          IDLE: begin
            cnt_q <= '0;
            if ((need_warm_q || seed_hon) && (WARMUP > 0)) begin
              state_q <= WARM;
            end else begin
              state_q     <= RUN;
              need_warm_q <= 1'b0;
            end
          end
          WARM: begin
            if (cnt_q == WARMUP - 1) begin
              state_q     <= RUN;
              need_warm_q <= 1'b0;
            end else begin
              cnt_q <= cnt_q + 32'd1;
            end
          end
          RUN: begin
            if (step_en) begin
              out_data_q  <= word_d;
              out_valid_q <= 1'b1;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign busy      = (state_q == WARM);
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;

endmodule

// File: tb/tb_taus_urng_mc.sv
// tb/tb_taus_urng_mc.sv - directed bench for taus_urng_mc against a golden taus88 model
module tb_taus_urng_mc;

  localparam int          NCH    = 4;
  localparam int          WARMUP = 16;
  localparam logic [31:0] SEED1  = 32'h1234_5678;
  localparam logic [31:0] SEED2  = 32'h9ABC_DEF0;
  localparam logic [31:0] SEED3  = 32'h0FED_CBA9;
  localparam logic [31:0] STRIDE = 32'h9E37_79B9;

  logic              clk = 1'b0;
  logic              rst;
  logic              en;
  logic              seed_we;
  logic [1:0]        seed_ch;
  logic [1:0]        seed_sel;
  logic [31:0]       seed_data;
  logic              busy;
  logic              out_valid;
  logic              out_ready;
  logic [32*NCH-1:0] out_data;

  int checks = 0;
  int errors = 0;

  logic [31:0] g1 [NCH];
  logic [31:0] g2 [NCH];
  logic [31:0] g3 [NCH];

  always #5 clk = ~clk;

  taus_urng_mc #(
    .NCH(NCH), .SEED1(SEED1), .SEED2(SEED2), .SEED3(SEED3),
    .SEED_STRIDE(STRIDE), .WARMUP(WARMUP)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .seed_we(seed_we), .seed_ch(seed_ch),
    .seed_sel(seed_sel), .seed_data(seed_data), .busy(busy),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
  );

  function automatic logic [31:0] f1(input logic [31:0] s);
    logic [31:0] a, b;
    a = (s & 32'hFFFF_FFFE) << 12;
    b = ((s << 13) ^ s) >> 19;
    return a ^ b;
  endfunction

  function automatic logic [31:0] f2(input logic [31:0] s);
    logic [31:0] a, b;
    a = (s & 32'hFFFF_FFF8) << 4;
    b = ((s << 2) ^ s) >> 25;
    return a ^ b;
  endfunction

  function automatic logic [31:0] f3(input logic [31:0] s);
    logic [31:0] a, b;
    a = (s & 32'hFFFF_FFF0) << 17;
    b = ((s << 3) ^ s) >> 11;
    return a ^ b;
  endfunction

  task automatic gstep(input int n);
    for (int i = 0; i < n; i++)
      for (int c = 0; c < NCH; c++) begin
        g1[c] = f1(g1[c]);
        g2[c] = f2(g2[c]);
        g3[c] = f3(g3[c]);
      end
  endtask

  task automatic greset();
    for (int c = 0; c < NCH; c++) begin
      g1[c] = SEED1 + 32'(c) * STRIDE;
      g2[c] = SEED2 + 32'(c) * STRIDE;
      g3[c] = SEED3 + 32'(c) * STRIDE;
    end
  endtask

  function automatic logic [32*NCH-1:0] gvec();
    logic [32*NCH-1:0] v;
    for (int c = 0; c < NCH; c++) v[32*c +: 32] = g1[c] ^ g2[c] ^ g3[c];
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Waits (bounded) for out_valid; k = edges taken including the IDLE exit edge.
  task automatic wait_valid(output int k, output int nbusy);
    k = 0;
    nbusy = 0;
    while (k < 60) begin
      tick();
      k++;
      if (busy) nbusy++;
      if (out_valid) break;
    end
  endtask

  task automatic seed_write(input logic [1:0] ch, input logic [1:0] sel, input logic [31:0] d);
    seed_ch   = ch;
    seed_sel  = sel;
    seed_data = d;
    seed_we   = 1'b1;
    tick();
    seed_we   = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b0; seed_we = 1'b0; seed_ch = '0; seed_sel = '0;
    seed_data = '0; out_ready = 1'b1;
    #22;
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || out_data !== '0) begin
      errors++;
      $display("FAIL reset_state valid=%b busy=%b data=%h required 0/0/0", out_valid, busy, out_data);
    end
    rst = 1'b0;
    tick();
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_reset valid=%b busy=%b required 0/0", out_valid, busy);
    end
    greset();
  endtask

  task automatic test_warmup();
    int k, nb;
    en = 1'b1;
    out_ready = 1'b1;
    wait_valid(k, nb);
    checks++;
    if (nb !== WARMUP) begin
      errors++;
      $display("FAIL warm_busy_cycles got %0d required %0d", nb, WARMUP);
    end
    checks++;
    if (k - 1 !== WARMUP + 1) begin
      errors++;
      $display("FAIL first_valid_edge got %0d required %0d", k - 1, WARMUP + 1);
    end
    gstep(WARMUP + 1);
    checks++;
    if (out_data !== gvec()) begin
      errors++;
      $display("FAIL first_word got %h required %h", out_data, gvec());
    end
    for (int n = 0; n < 1000; n++) begin
      tick();
      gstep(1);
      checks++;
      if (out_valid !== 1'b1 || out_data !== gvec()) begin
        errors++;
        $display("FAIL stream_word %0d valid=%b got %h required %h", n, out_valid, out_data, gvec());
      end
    end
  endtask

  task automatic test_backpressure();
    logic [32*NCH-1:0] held;
    held = gvec();
    out_ready = 1'b0;
    for (int n = 0; n < 10; n++) begin
      tick();
      checks++;
      if (out_valid !== 1'b1 || out_data !== held) begin
        errors++;
        $display("FAIL stall_hold %0d valid=%b got %h required %h", n, out_valid, out_data, held);
      end
    end
    out_ready = 1'b1;
    tick();
    gstep(1);
    checks++;
    if (out_valid !== 1'b1 || out_data !== gvec()) begin
      errors++;
      $display("FAIL after_stall got %h required %h", out_data, gvec());
    end
  endtask

  task automatic test_seed_ignored_in_run();
    seed_ch = 2'd1; seed_sel = 2'd0; seed_data = 32'h0; seed_we = 1'b1;
    tick();
    seed_we = 1'b0;
    gstep(1);
    for (int n = 0; n < 3; n++) begin
      checks++;
      if (busy !== 1'b0 || out_data !== gvec()) begin
        errors++;
        $display("FAIL seed_in_run %0d busy=%b got %h required %h", n, busy, out_data, gvec());
      end
      tick();
      gstep(1);
    end
  endtask

  task automatic test_pause();
    int k, nb;
    en = 1'b0;
    for (int n = 0; n < 5; n++) begin
      tick();
      checks++;
      if (busy !== 1'b0 || out_valid !== 1'b0) begin
        errors++;
        $display("FAIL pause_state %0d busy=%b valid=%b required 0/0", n, busy, out_valid);
      end
    end
    en = 1'b1;
    wait_valid(k, nb);
    checks++;
    if (k !== 2 || nb !== 0) begin
      errors++;
      $display("FAIL resume_latency edges=%0d busy=%0d required 2/0", k, nb);
    end
    gstep(1);
    checks++;
    if (out_data !== gvec()) begin
      errors++;
      $display("FAIL resume_word got %h required %h", out_data, gvec());
    end
  endtask

  task automatic test_seed_write();
    int k, nb;
    en = 1'b0;
    tick();
    seed_write(2'd2, 2'd0, 32'd1);
    seed_write(2'd2, 2'd1, 32'd2);
    seed_write(2'd2, 2'd2, 32'd3);
`ifdef TAUS_SEED_FIX_EN
    g1[2] = 32'd3; g2[2] = 32'd10; g3[2] = 32'd19;
`else
    g1[2] = 32'd1; g2[2] = 32'd2; g3[2] = 32'd3;
`endif
    en = 1'b1;
    wait_valid(k, nb);
    checks++;
    if (k - 1 !== WARMUP + 1 || nb !== WARMUP) begin
      errors++;
      $display("FAIL seed_warm edges=%0d busy=%0d required %0d/%0d", k - 1, nb, WARMUP + 1, WARMUP);
    end
    gstep(WARMUP + 1);
    for (int n = 0; n < 10; n++) begin
      checks++;
      if (out_data !== gvec()) begin
        errors++;
        $display("FAIL seed_ch2 %0d got %h required %h", n, out_data, gvec());
      end
      tick();
      gstep(1);
    end
  endtask

  task automatic test_zero_seed();
    int k, nb;
    en = 1'b0;
    tick();
    seed_write(2'd0, 2'd0, 32'd0);
    seed_write(2'd0, 2'd1, 32'd0);
    seed_write(2'd0, 2'd2, 32'd0);
`ifdef TAUS_SEED_FIX_EN
    g1[0] = 32'd2; g2[0] = 32'd8; g3[0] = 32'd16;
`else
    g1[0] = 32'd0; g2[0] = 32'd0; g3[0] = 32'd0;
`endif
    en = 1'b1;
    wait_valid(k, nb);
    gstep(WARMUP + 1);
    for (int n = 0; n < 10; n++) begin
      checks++;
      if (out_data !== gvec()) begin
        errors++;
        $display("FAIL zero_seed %0d got %h required %h", n, out_data, gvec());
      end
`ifdef TAUS_SEED_FIX_EN
      checks++;
      if (out_data[31:0] === 32'd0) begin
        errors++;
        $display("FAIL zero_seed_fixed %0d ch0=%h required nonzero", n, out_data[31:0]);
      end
`else
      checks++;
      if (out_data[31:0] !== 32'd0) begin
        errors++;
        $display("FAIL zero_seed_stuck %0d ch0=%h required 0", n, out_data[31:0]);
      end
`endif
      tick();
      gstep(1);
    end
  endtask

  task automatic test_async_reset();
    int k, nb;
    #3;
    rst = 1'b1;
    en  = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || out_data !== '0) begin
      errors++;
      $display("FAIL async_reset valid=%b busy=%b data=%h required 0/0/0", out_valid, busy, out_data);
    end
    #2;
    rst = 1'b0;
    #1;
    greset();
    en = 1'b1;
    wait_valid(k, nb);
    checks++;
    if (k - 1 !== WARMUP + 1 || nb !== WARMUP) begin
      errors++;
      $display("FAIL restart_warm edges=%0d busy=%0d required %0d/%0d", k - 1, nb, WARMUP + 1, WARMUP);
    end
    gstep(WARMUP + 1);
    for (int n = 0; n < 5; n++) begin
      checks++;
      if (out_data !== gvec()) begin
        errors++;
        $display("FAIL restart_word %0d got %h required %h", n, out_data, gvec());
      end
      tick();
      gstep(1);
    end
  endtask

  initial begin
    test_reset();
    test_warmup();
    test_backpressure();
    test_seed_ignored_in_run();
    test_pause();
    test_seed_write();
    test_zero_seed();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
